// File: rtl/lab_event_sched.sv
// lab_event_sched: four-LAB trigger/digitize/readout ring scheduler.
// Triggers freeze LABs in ring order, a single digitize engine converts
// them one at a time in the same order, and the host releases them in order.
// Optional digitize watchdog is enabled by defining LAB_SCHED_TIMEOUT_EN.
module lab_event_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    output logic [3:0]  hold_o,
    output logic [3:0]  digitize_o,
    input  logic [3:0]  done_i,
    output logic [3:0]  ready_o,
    output logic [1:0]  rd_lab_o,
    output logic        rd_valid_o,
    input  logic        release_i,
    output logic        busy_o,
    output logic [15:0] drop_cnt_o,
    output logic [3:0]  err_o
);

    typedef enum logic [1:0] {
        LAB_FREE,
        LAB_HELD,
        LAB_DIGI,
        LAB_READY
    } lab_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_ISSUE,
        ENG_ARM,
        ENG_WAIT
    } eng_state_t;

    lab_state_t  lab_q [4];
    eng_state_t  eng_q;
    eng_state_t  eng_d;
    logic [1:0]  wptr_q;
    logic [1:0]  dptr_q;
    logic [1:0]  rptr_q;
    logic [15:0] drop_q;

    logic        busy;
    logic        alloc;
    logic        drop;
    logic        release_ok;
    logic        issue_fire;
    logic        done_fire;
    logic        timeout_fire;
    logic        wd_expired;

    // Trigger and release decisions use only start-of-cycle LAB state, so a
    // LAB freed this cycle cannot be re-allocated in the same cycle.
    assign busy       = (lab_q[wptr_q] != LAB_FREE);
    assign alloc      = trig_i & ~busy;
    assign drop       = trig_i & busy;
    assign release_ok = release_i & (lab_q[rptr_q] == LAB_READY);

    assign busy_o     = busy;
    assign rd_lab_o   = rptr_q;
    assign rd_valid_o = (lab_q[rptr_q] == LAB_READY);
    assign drop_cnt_o = drop_q;
    assign digitize_o = issue_fire ? (4'b0001 << dptr_q) : 4'b0000;

    // Per-LAB hold and ready flags decoded from the LAB state array.
    always_comb begin
        hold_o  = 4'b0000;
        ready_o = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hold_o[i]  = (lab_q[i] != LAB_FREE);
            ready_o[i] = (lab_q[i] == LAB_READY);
        end
    end

    // Digitize engine state register; reset abandons any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eng_q <= ENG_IDLE;
        end else begin
            eng_q <= eng_d;
        end
    end

    // Digitize engine next state: ARM waits for done to drop, WAIT for it to rise.
    always_comb begin
        eng_d        = eng_q;
        issue_fire   = 1'b0;
        done_fire    = 1'b0;
        timeout_fire = 1'b0;
        case (eng_q)
            ENG_IDLE: begin
                if (lab_q[dptr_q] == LAB_HELD) begin
                    eng_d = ENG_ISSUE;
                end
            end
            ENG_ISSUE: begin
                issue_fire = 1'b1;
                eng_d      = ENG_ARM;
            end
            ENG_ARM: begin
                if (wd_expired) begin
                    timeout_fire = 1'b1;
                    eng_d        = ENG_IDLE;
                end else if (!done_i[dptr_q]) begin
                    eng_d = ENG_WAIT;
                end
            end
            ENG_WAIT: begin
                if (done_i[dptr_q]) begin
                    done_fire = 1'b1;
                    eng_d     = ENG_IDLE;
                end else if (wd_expired) begin
                    timeout_fire = 1'b1;
                    eng_d        = ENG_IDLE;
                end
            end
            default: eng_d = ENG_IDLE;
        endcase
    end

    // LAB state array, ring pointers and drop counter; the three writers always
    // target LABs in different states, so they never collide on one entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                lab_q[i] <= LAB_FREE;
            end
            wptr_q <= 2'd0;
            dptr_q <= 2'd0;
            rptr_q <= 2'd0;
            drop_q <= 16'd0;
        end else begin
            if (alloc) begin
                lab_q[wptr_q] <= LAB_HELD;
                wptr_q        <= wptr_q + 2'd1;
            end
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            if (issue_fire) begin
                lab_q[dptr_q] <= LAB_DIGI;
            end
            if (done_fire || timeout_fire) begin
                lab_q[dptr_q] <= LAB_READY;
                dptr_q        <= dptr_q + 2'd1;
            end
            if (release_ok) begin
                lab_q[rptr_q] <= LAB_FREE;
                rptr_q        <= rptr_q + 2'd1;
            end
        end
    end

`ifdef LAB_SCHED_TIMEOUT_EN
    logic [16:0] wd_cnt_q;
    logic [3:0]  err_q;

    assign wd_expired = (wd_cnt_q == 17'(TIMEOUT_CYCLES - 1));
    assign err_o      = err_q;

    // Watchdog counts ARM/WAIT cycles; error flags stay set until the LAB is released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= 17'd0;
            err_q    <= 4'b0000;
        end else begin
            if (issue_fire) begin
                wd_cnt_q <= 17'd0;
            end else if ((eng_q == ENG_ARM) || (eng_q == ENG_WAIT)) begin
                wd_cnt_q <= wd_cnt_q + 17'd1;
            end
            if (timeout_fire) begin
                err_q[dptr_q] <= 1'b1;
            end
            if (release_ok) begin
                err_q[rptr_q] <= 1'b0;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err_o      = 4'b0000;
`endif

endmodule

// File: tb/tb_lab_event_sched.sv
// tb_lab_event_sched: directed scenario bench for lab_event_sched.
// The watchdog scenario is included only when LAB_SCHED_TIMEOUT_EN is defined.
module tb_lab_event_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trig_i;
    logic [3:0]  hold_o;
    logic [3:0]  digitize_o;
    logic [3:0]  done_i;
    logic [3:0]  ready_o;
    logic [1:0]  rd_lab_o;
    logic        rd_valid_o;
    logic        release_i;
    logic        busy_o;
    logic [15:0] drop_cnt_o;
    logic [3:0]  err_o;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  dig_seq [16];
    int          dig_n  = 0;
    int          served = 0;

    lab_event_sched #(.TIMEOUT_CYCLES(50)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .trig_i     (trig_i),
        .hold_o     (hold_o),
        .digitize_o (digitize_o),
        .done_i     (done_i),
        .ready_o    (ready_o),
        .rd_lab_o   (rd_lab_o),
        .rd_valid_o (rd_valid_o),
        .release_i  (release_i),
        .busy_o     (busy_o),
        .drop_cnt_o (drop_cnt_o),
        .err_o      (err_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout reached without finishing");
        $fatal(1, "[TB] time limit");
    end

    // Advance one cycle and log any digitize pulse seen.
    task automatic step();
        @(posedge clk_i);
        #1;
        if ((digitize_o !== 4'b0000) && (dig_n < 16)) begin
            dig_seq[dig_n] = digitize_o;
            dig_n++;
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        rst_i     = 1'b1;
        trig_i    = 1'b0;
        release_i = 1'b0;
        step();
        rst_i  = 1'b0;
        dig_n  = 0;
        served = 0;
    endtask

    // Complete conversions in pulse order: drop done, then raise it again.
    task automatic serve_done(input int n);
        int budget = 0;
        int lab;
        while ((served < n) && (budget < 500)) begin
            if (dig_n > served) begin
                lab = onehot_idx(dig_seq[served]);
                done_i[lab] = 1'b0;
                step();
                step();
                done_i[lab] = 1'b1;
                step();
                step();
                served++;
            end else begin
                step();
            end
            budget++;
        end
        checks++;
        if (served != n) begin
            errors++;
            $display("[TB] FAIL serve_done served=%0d exp=%0d", served, n);
        end
    endtask

    task automatic test_reset();
        rst_i     = 1'b1;
        trig_i    = 1'b1;
        release_i = 1'b1;
        done_i    = 4'b1111;
        step();
        step();
        checks++;
        if ({hold_o, digitize_o, ready_o, err_o} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_vec got=%h exp=0000", {hold_o, digitize_o, ready_o, err_o});
        end
        checks++;
        if ({rd_lab_o, rd_valid_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ptr got=%b exp=0000", {rd_lab_o, rd_valid_o, busy_o});
        end
        checks++;
        if (drop_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop got=%0d exp=0", drop_cnt_o);
        end
        rst_i     = 1'b0;
        trig_i    = 1'b0;
        release_i = 1'b0;
        step();
        checks++;
        if (hold_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_trig_ignored got=%b exp=0000", hold_o);
        end
    endtask

    task automatic test_single_event();
        do_reset();
        done_i = 4'b1111;
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        checks++;
        if ({hold_o, digitize_o} !== 8'b0001_0000) begin
            errors++;
            $display("[TB] FAIL single_hold got=%b exp=00010000", {hold_o, digitize_o});
        end
        step();
        checks++;
        if (digitize_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_digitize got=%b exp=0001", digitize_o);
        end
        step();
        checks++;
        if (digitize_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_digitize_once got=%b exp=0000", digitize_o);
        end
        done_i[0] = 1'b0;
        for (int c = 0; c < 27; c++) begin
            step();
            release_i = (c == 0);
        end
        release_i = 1'b0;
        checks++;
        if ({ready_o, rd_valid_o, hold_o} !== 9'b0000_0_0001) begin
            errors++;
            $display("[TB] FAIL single_waiting got=%b exp=000000001", {ready_o, rd_valid_o, hold_o});
        end
        done_i[0] = 1'b1;
        step();
        checks++;
        if ({ready_o, rd_valid_o, rd_lab_o} !== 7'b0001_1_00) begin
            errors++;
            $display("[TB] FAIL single_ready got=%b exp=0001100", {ready_o, rd_valid_o, rd_lab_o});
        end
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if ({hold_o, ready_o, rd_lab_o, busy_o} !== 11'b0000_0000_01_0) begin
            errors++;
            $display("[TB] FAIL single_release got=%b exp=00000000010", {hold_o, ready_o, rd_lab_o, busy_o});
        end
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        checks++;
        if (hold_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_wptr_next got=%b exp=0010", hold_o);
        end
        step();
        checks++;
        if (digitize_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_dptr_next got=%b exp=0010", digitize_o);
        end
        checks++;
        if (err_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_err got=%b exp=0000", err_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        done_i = 4'b1111;
        trig_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({hold_o, busy_o, drop_cnt_o} !== {4'b1111, 1'b1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL overflow_full got hold=%b busy=%b drop=%0d exp hold=1111 busy=1 drop=0", hold_o, busy_o, drop_cnt_o);
        end
        step();
        trig_i = 1'b0;
        step();
        checks++;
        if ({hold_o, busy_o, drop_cnt_o} !== {4'b1111, 1'b1, 16'd1}) begin
            errors++;
            $display("[TB] FAIL overflow_drop got hold=%b busy=%b drop=%0d exp hold=1111 busy=1 drop=1", hold_o, busy_o, drop_cnt_o);
        end
        checks++;
        if ({ready_o, rd_valid_o, rd_lab_o} !== 7'b0000_0_00) begin
            errors++;
            $display("[TB] FAIL overflow_nochange got=%b exp=0000000", {ready_o, rd_valid_o, rd_lab_o});
        end
        checks++;
        if (dig_n != 1) begin
            errors++;
            $display("[TB] FAIL overflow_one_digi got=%0d exp=1", dig_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        do_reset();
        done_i = 4'b1111;
        trig_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        trig_i = 1'b0;
        serve_done(3);
        checks++;
        if (dig_n != 3) begin
            errors++;
            $display("[TB] FAIL order_count got=%0d exp=3", dig_n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dig_seq[i] !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL order_pulse%0d got=%b exp=%b", i, dig_seq[i], exp_seq[i]);
            end
        end
        checks++;
        if ({ready_o, hold_o} !== 8'b0111_0111) begin
            errors++;
            $display("[TB] FAIL order_ready got=%b exp=01110111", {ready_o, hold_o});
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rd_valid_o, rd_lab_o} !== {1'b1, 2'(k)}) begin
                errors++;
                $display("[TB] FAIL order_rd%0d got=%b exp=%b", k, {rd_valid_o, rd_lab_o}, {1'b1, 2'(k)});
            end
            release_i = 1'b1;
            step();
            release_i = 1'b0;
        end
        checks++;
        if ({hold_o, rd_valid_o, rd_lab_o} !== 7'b0000_0_11) begin
            errors++;
            $display("[TB] FAIL order_end got=%b exp=0000011", {hold_o, rd_valid_o, rd_lab_o});
        end
    endtask

    task automatic test_wrap_simultaneous();
        do_reset();
        done_i = 4'b1111;
        trig_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        trig_i = 1'b0;
        serve_done(4);
        checks++;
        if ({ready_o, busy_o, rd_lab_o} !== 7'b1111_1_00) begin
            errors++;
            $display("[TB] FAIL wrap_full got=%b exp=1111100", {ready_o, busy_o, rd_lab_o});
        end
        checks++;
        if (dig_seq[3] !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL wrap_pulse3 got=%b exp=1000", dig_seq[3]);
        end
        release_i = 1'b1;
        trig_i    = 1'b1;
        step();
        release_i = 1'b0;
        trig_i    = 1'b0;
        checks++;
        if ({hold_o, busy_o, drop_cnt_o} !== {4'b1110, 1'b0, 16'd1}) begin
            errors++;
            $display("[TB] FAIL wrap_simul got hold=%b busy=%b drop=%0d exp hold=1110 busy=0 drop=1", hold_o, busy_o, drop_cnt_o);
        end
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        checks++;
        if ({hold_o, busy_o} !== 5'b1111_1) begin
            errors++;
            $display("[TB] FAIL wrap_realloc got=%b exp=11111", {hold_o, busy_o});
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if ({rd_valid_o, rd_lab_o} !== {1'b1, 2'(k)}) begin
                errors++;
                $display("[TB] FAIL wrap_rd%0d got=%b exp=%b", k, {rd_valid_o, rd_lab_o}, {1'b1, 2'(k)});
            end
            release_i = 1'b1;
            step();
            release_i = 1'b0;
        end
        serve_done(5);
        checks++;
        if ({dig_seq[4], ready_o, rd_valid_o, rd_lab_o} !== 11'b0001_0001_1_00) begin
            errors++;
            $display("[TB] FAIL wrap_lab0_again got=%b exp=00010001100", {dig_seq[4], ready_o, rd_valid_o, rd_lab_o});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        done_i = 4'b1111;
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        step();
        done_i[0] = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        dig_n = 0;
        checks++;
        if ({hold_o, digitize_o, ready_o, err_o, rd_lab_o, rd_valid_o, busy_o} !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL midreset_outs got=%b exp=0", {hold_o, digitize_o, ready_o, err_o, rd_lab_o, rd_valid_o, busy_o});
        end
        done_i[0] = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if ({dig_n[3:0], ready_o} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_nopulse got pulses=%0d ready=%b exp pulses=0 ready=0000", dig_n, ready_o);
        end
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        checks++;
        if (hold_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midreset_alloc got=%b exp=0001", hold_o);
        end
        step();
        checks++;
        if (digitize_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midreset_digi got=%b exp=0001", digitize_o);
        end
    endtask

`ifdef LAB_SCHED_TIMEOUT_EN
    task automatic test_watchdog();
        do_reset();
        done_i = 4'b0000;
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        step();
        for (int k = 0; k < 50; k++) step();
        checks++;
        if ({ready_o, err_o} !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL wd_early got=%b exp=00000000", {ready_o, err_o});
        end
        step();
        checks++;
        if ({ready_o, err_o, rd_valid_o} !== 9'b0001_0001_1) begin
            errors++;
            $display("[TB] FAIL wd_expire got=%b exp=000100011", {ready_o, err_o, rd_valid_o});
        end
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if ({err_o, hold_o} !== 8'b0000_0000) begin
            errors++;
            $display("[TB] FAIL wd_release got=%b exp=00000000", {err_o, hold_o});
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        rst_i     = 1'b1;
        trig_i    = 1'b0;
        release_i = 1'b0;
        done_i    = 4'b1111;
        test_reset();
        test_single_event();
        test_overflow();
        test_back_to_back();
        test_wrap_simultaneous();
        test_reset_mid();
`ifdef LAB_SCHED_TIMEOUT_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab_event_sched.md
LAB_EVENT_SCHED -- requirements
Module: lab_event_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, digitize watchdog limit in clk_i cycles (used only with LAB_SCHED_TIMEOUT_EN).
REQ-002 clk_i  input  1  single clock for all logic.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 trig_i  input  1  one-cycle trigger request; freezes the next LAB in the ring.
REQ-005 hold_o  output  4  per-LAB hold, bit i drives LAB i hold/NRUN.
REQ-006 digitize_o  output  4  one-cycle digitize pulse per LAB.
REQ-007 done_i  input  4  per-LAB readout-complete level; cleared by digitize, set when the RAM is filled.
REQ-008 ready_o  output  4  per-LAB event stored and readable.
REQ-009 rd_lab_o  output  2  index of the oldest LAB, for the read address [12:11].
REQ-010 rd_valid_o  output  1  ready_o[rd_lab_o] is high.
REQ-011 release_i  input  1  one-cycle host release of LAB rd_lab_o.
REQ-012 busy_o  output  1  no LAB is FREE at wptr; a trigger now is dropped.
REQ-013 drop_cnt_o  output  16  saturating count of dropped triggers.
REQ-014 err_o  output  4  per-LAB watchdog error, sticky until release.

Function
REQ-015 Each LAB SHALL have a state: FREE, HELD, DIGI or READY.
REQ-016 hold_o[i] SHALL be high in every state except FREE.
REQ-017 There SHALL be three 2-bit ring pointers: wptr (allocate), dptr (digitize) and rptr (read); each wraps from 3 to 0.
REQ-018 Trigger: if trig_i is high and LAB[wptr] is FREE at the start of the cycle, then LAB[wptr] SHALL go to HELD and wptr SHALL increment; hold_o SHALL rise on the next cycle.
REQ-019 Trigger drop: if trig_i is high and LAB[wptr] is not FREE, the trigger SHALL be dropped, drop_cnt_o SHALL increment (saturating at 0xFFFF) and no state SHALL change.
REQ-020 The digitize engine SHALL have four states: IDLE, ISSUE, ARM and WAIT.
REQ-021 IDLE goes to ISSUE when LAB[dptr] is HELD.
REQ-022 ISSUE SHALL assert digitize_o[dptr] for exactly one cycle, move LAB[dptr] to DIGI and go to ARM.
REQ-023 ARM goes to WAIT when done_i[dptr] is 0.
REQ-024 WAIT goes to IDLE when done_i[dptr] is 1; LAB[dptr] then goes to READY and dptr increments.
REQ-025 Only one LAB SHALL be in DIGI at a time.
REQ-026 Minimum latency: trig_i at cycle N gives hold_o at N+1 and digitize_o at N+2.
REQ-027 rd_lab_o SHALL equal rptr, and rd_valid_o SHALL be high when LAB[rptr] is READY.
REQ-028 Release: release_i while rd_valid_o is high SHALL move LAB[rptr] to FREE, clear err_o[rptr] and increment rptr.
REQ-029 release_i while rd_valid_o is low SHALL be ignored.
REQ-030 A release and a trigger in the same cycle SHALL both be processed; the trigger SHALL use the start-of-cycle state, so a LAB freed in that cycle is not allocated in that cycle.
REQ-031 busy_o SHALL be high when LAB[wptr] is not FREE; it is combinational from registered state.
REQ-032 Events SHALL be digitized and presented for readout strictly in trigger order.
REQ-033 With all four LABs READY, ring order 0,1,2,3 SHALL be preserved through wrap-around.

Reset
REQ-034 When rst_i is high at a clock edge, the block SHALL reset as follows:
- all LABs FREE, all pointers 0, engine IDLE;
- hold_o, digitize_o, ready_o, err_o, drop_cnt_o, rd_lab_o, rd_valid_o all 0.
REQ-035 busy_o SHALL be 0 after reset.
REQ-036 A reset during ARM or WAIT SHALL abandon the digitization; no digitize_o pulse SHALL follow the reset.

Configuration
REQ-037 Macro LAB_SCHED_TIMEOUT_EN controls the digitize watchdog.
REQ-038 With LAB_SCHED_TIMEOUT_EN defined:
- a 17-bit counter SHALL clear in ISSUE and count in ARM/WAIT;
- on reaching TIMEOUT_CYCLES, LAB[dptr] SHALL go to READY, err_o[dptr] SHALL be set, dptr SHALL increment and the engine SHALL return to IDLE.
REQ-039 Without LAB_SCHED_TIMEOUT_EN, there SHALL be no counter, err_o SHALL be tied to 0, and the engine SHALL wait on done_i indefinitely.

Verification
REQ-040 Single event:
- stimulus: reset, trig_i at cycle 10, done_i falls at 13 and rises at 40;
- response: hold_o=0001 at 11, digitize_o=0001 at 12 only, ready_o=0001 at 41, rd_lab_o=0;
- then release_i: hold_o=0000, and wptr, dptr and rptr are all 1.
REQ-041 Overflow:
- stimulus: 5 triggers with no release;
- response: hold_o=1111, busy_o=1, drop_cnt_o=1, the fifth trigger changes no state.
REQ-042 Ordering:
- stimulus: 3 back-to-back triggers, done_i returned in order, then 3 releases;
- response: digitize_o pulses 0001, 0010, 0100 in order, rd_lab_o sequence 0,1,2, hold_o ends at 0000.
REQ-043 Wrap and simultaneous events:
- stimulus: fill all 4 LABs, release LAB0 and trigger in the same cycle;
- response: trigger dropped, LAB0 FREE; the next trigger takes LAB0.
REQ-044 Reset mid-operation:
- stimulus: rst_i high for 1 cycle during WAIT;
- response: all outputs 0 next cycle, no digitize_o pulse afterward, a new trigger allocates LAB0.
REQ-045 Watchdog, with LAB_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50:
- stimulus: trigger, done_i held low;
- response: at the 50th ARM/WAIT cycle, ready_o[0]=1 and err_o[0]=1; release clears err_o[0].
